// File: rtl/vertex_loader.sv
// Vertex loader: captures a 4x4 matrix from a 32-bit word stream, then assembles
// x/y/z/w vertex groups and presents each one to the transform stage until accepted.
module vertex_loader (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_matrix,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [127:0]  matrix_out [3:0],
    output logic          matrix_valid,
    output logic [31:0]   x_out,
    output logic [31:0]   y_out,
    output logic [31:0]   z_out,
    output logic [31:0]   w_out,
    output logic          vtx_valid,
    input  logic          vtx_ready,
    output logic          busy,
    output logic [15:0]   vtx_count
);

    typedef enum logic [1:0] {IDLE, LOAD_M, GATHER, PRESENT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        matrix_valid_reg, matrix_valid_next;
    logic [15:0] vtx_count_reg, vtx_count_next;
    logic        load_word;
    logic        vtx_word;
    logic [31:0] matrix_words [16];
    logic [31:0] vtx_words [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            matrix_valid_reg <= 1'b0;
            vtx_count_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            matrix_valid_reg <= matrix_valid_next;
            vtx_count_reg    <= vtx_count_next;
        end
    end

    // in_ready depends only on registered state plus load_matrix; vtx_ready never reaches it.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        matrix_valid_next = matrix_valid_reg;
        vtx_count_next    = vtx_count_reg;
        in_ready          = 1'b0;
        vtx_valid         = 1'b0;
        load_word         = 1'b0;
        vtx_word          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_matrix) begin
                    state_next = LOAD_M;
                    cnt_next   = '0;
                end
            end
            LOAD_M: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_word = 1'b1;
                    if (cnt_reg == 4'd15) begin
                        state_next        = GATHER;
                        cnt_next          = '0;
                        matrix_valid_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            GATHER: begin
                // A reload can only start between vertices, and it wins over any offered word.
                if (cnt_reg == 4'd0 && load_matrix) begin
                    state_next        = LOAD_M;
                    matrix_valid_next = 1'b0;
                    vtx_count_next    = '0;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        vtx_word = 1'b1;
                        if (cnt_reg == 4'd3) begin
                            state_next = PRESENT;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end
                end
            end
            PRESENT: begin
                vtx_valid = 1'b1;
                if (vtx_ready) begin
                    state_next     = GATHER;
                    cnt_next       = '0;
                    vtx_count_next = vtx_count_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_mword
            logic [31:0] word_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    word_reg <= '0;
                else if (load_word && cnt_reg == 4'(gi))
                    word_reg <= in_data;
            end
            assign matrix_words[gi] = word_reg;
        end

        // Column 0 of each row sits in the most significant word.
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign matrix_out[gi] = {matrix_words[4*gi], matrix_words[4*gi+1],
                                     matrix_words[4*gi+2], matrix_words[4*gi+3]};
        end

        for (gi = 0; gi < 4; gi++) begin : g_vword
            logic [31:0] comp_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    comp_reg <= '0;
                else if (vtx_word && cnt_reg[1:0] == 2'(gi))
                    comp_reg <= in_data;
            end
            assign vtx_words[gi] = comp_reg;
        end
    endgenerate

    assign x_out        = vtx_words[0];
    assign y_out        = vtx_words[1];
    assign z_out        = vtx_words[2];
    assign w_out        = vtx_words[3];
    assign matrix_valid = matrix_valid_reg;
    assign vtx_count    = vtx_count_reg;
    assign busy         = (state_reg != IDLE);

endmodule
